// File: rtl/muller_pkg.sv
// Shared definitions for the Muller C-element micropipeline: reset value of
// every C-element and the width helper for occupancy counters.
package muller_pkg;

    localparam logic C_RESET = 1'b0;

    // Bits needed to count 0..n inclusive.
    function automatic int clog2p1(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/muller_c_n.sv
// Generic N-input synchronous C-element: output follows the inputs when they
// all agree and holds otherwise.
module muller_c_n
    import muller_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic [N-1:0] in,
    output logic         c
);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            c <= C_RESET;
        end else if (&in) begin
            c <= 1'b1;
        end else if (~|in) begin
            c <= 1'b0;
        end
    end

endmodule

// File: rtl/muller_c_pipeline.sv
// Clocked two-phase micropipeline: an N_IN-way join C-element followed by a
// chain of C-element/latch stages, with occupancy and empty/full status.
module muller_c_pipeline
    import muller_pkg::*;
#(
    parameter int STAGES = 4,
    parameter int WIDTH  = 8,
    parameter int N_IN   = 2
) (
    input  logic                           wb_clk_i,
    input  logic                           wb_rst_i,
    input  logic [N_IN-1:0]                in_req,
    input  logic [N_IN*WIDTH-1:0]          in_data,
    output logic                           in_ack,
    output logic                           out_req,
    output logic [N_IN*WIDTH-1:0]          out_data,
    input  logic                           out_ack,
    output logic [clog2p1(STAGES)-1:0]     occupancy,
    output logic                           empty,
    output logic                           full
);

    localparam int DW = N_IN * WIDTH;
    localparam int OW = clog2p1(STAGES);

    logic [STAGES-1:0]          c;
    logic [STAGES:0]            c_ext;
    logic [STAGES-1:0]          chg;
    logic [STAGES-1:0][DW-1:0]  d;
    logic [STAGES-1:0][DW-1:0]  d_src;

    // c_ext[STAGES] stands in for the consumer acknowledge
    assign c_ext = {out_ack, c};
    assign d_src = {d[STAGES-2:0], in_data};

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        if (i == 0) begin : g_head
            logic [N_IN:0] ins;
            assign ins = {in_req, ~c_ext[1]};

            muller_c_n #(.N(N_IN + 1)) u_c (
                .wb_clk_i (wb_clk_i),
                .wb_rst_i (wb_rst_i),
                .in       (ins),
                .c        (c[i])
            );

            assign chg[i] = (&ins & ~c[i]) | (~|ins & c[i]);
        end else begin : g_body
            logic [1:0] ins;
            assign ins = {c_ext[i-1], ~c_ext[i+1]};

            muller_c_n #(.N(2)) u_c (
                .wb_clk_i (wb_clk_i),
                .wb_rst_i (wb_rst_i),
                .in       (ins),
                .c        (c[i])
            );

            assign chg[i] = (&ins & ~c[i]) | (~|ins & c[i]);
        end
    end

    // Data latches capture their predecessor exactly when their C-element fires
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            d <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (chg[i]) begin
                    d[i] <= d_src[i];
                end
            end
        end
    end

    // A stage holds a token when its phase differs from its successor's
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < STAGES; i++) begin
            occupancy = occupancy + OW'(c_ext[i] ^ c_ext[i+1]);
        end
    end

    assign in_ack   = c[0];
    assign out_req  = c[STAGES-1];
    assign out_data = d[STAGES-1];
    assign empty    = (occupancy == '0);
    assign full     = (occupancy == OW'(STAGES));

endmodule

// File: tb/tb_muller_c_pipeline.sv
// Scoreboard bench for muller_c_pipeline at default parameters.
module tb_muller_c_pipeline;

    localparam int STAGES = 4;
    localparam int WIDTH  = 8;
    localparam int N_IN   = 2;
    localparam int DW     = N_IN * WIDTH;
    localparam int OW     = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [N_IN-1:0] in_req;
    logic [DW-1:0]   in_data;
    logic            in_ack;
    logic            out_req;
    logic [DW-1:0]   out_data;
    logic            out_ack;
    logic [OW-1:0]   occupancy;
    logic            empty;
    logic            full;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] sb[$];

    muller_c_pipeline #(.STAGES(STAGES), .WIDTH(WIDTH), .N_IN(N_IN)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .in_req    (in_req),
        .in_data   (in_data),
        .in_ack    (in_ack),
        .out_req   (out_req),
        .out_data  (out_data),
        .out_ack   (out_ack),
        .occupancy (occupancy),
        .empty     (empty),
        .full      (full)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Producer: wait for the join to be idle, then present a new token.
    task automatic offer(input logic [DW-1:0] val);
        bit ready = 0;
        for (int i = 0; i < 50 && !ready; i++) begin
            if (in_req == {N_IN{in_ack}}) ready = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        check_val("offer_ready", 32'(ready), 32'd1);
        if (ready) begin
            in_data = val;
            in_req  = ~in_req;
            sb.push_back(val);
        end
    endtask

    // Consumer: acknowledge every head token until the scoreboard and pipeline are empty.
    task automatic drain(input int max_cyc);
        bit done = 0;
        for (int i = 0; i < max_cyc && !done; i++) begin
            @(posedge clk); #1;
            if (out_req != out_ack) begin
                if (sb.size() == 0) check_val("spurious_token", 32'(sb.size()), 32'd1);
                else check_val("drain_data", 32'(out_data), 32'(sb.pop_front()));
                out_ack = ~out_ack;
                #1;
            end
            if (sb.size() == 0 && occupancy == '0) done = 1;
        end
        check_val("drain_done", 32'(done), 32'd1);
    endtask

    // Handshake protocol monitor on the bench's own stimulus
    logic [N_IN-1:0] prev_req;
    logic            prev_out_ack;
    logic            prev_rst = 1'b1;
    always @(posedge clk) begin
        if (!rst && !prev_rst) begin
            for (int k = 0; k < N_IN; k++)
                assert (in_req[k] == prev_req[k] || prev_req[k] == in_ack)
                    else $error("producer toggled channel %0d out of turn", k);
            assert (out_ack == prev_out_ack || prev_out_ack != out_req)
                else $error("consumer toggled out_ack out of turn");
        end
        prev_req     <= in_req;
        prev_out_ack <= out_ack;
        prev_rst     <= rst;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int delivered;
        int sent;
        int cyc;
        logic ack_before;

        rst = 1'b1; in_req = '0; in_data = '0; out_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_in_ack",    32'(in_ack),    32'd0);
        check_val("rst_out_req",   32'(out_req),   32'd0);
        check_val("rst_out_data",  32'(out_data),  32'h0000);
        check_val("rst_occupancy", 32'(occupancy), 32'd0);
        check_val("rst_empty",     32'(empty),     32'd1);
        check_val("rst_full",      32'(full),      32'd0);
        rst = 1'b0;

        // Single token latency through an empty pipeline
        in_data = 16'hA55A; in_req = 2'b11; sb.push_back(16'hA55A);
        @(posedge clk); #1;
        check_val("lat_in_ack",  32'(in_ack),    32'd1);
        check_val("lat_occ_e1",  32'(occupancy), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check_val("lat_out_req_e3", 32'(out_req), 32'd0);
        @(posedge clk); #1;
        check_val("lat_out_req_e4", 32'(out_req),   32'd1);
        check_val("lat_out_data",   32'(out_data),  32'(sb.pop_front()));
        check_val("lat_occ_e4",     32'(occupancy), 32'd1);
        out_ack = 1'b1; #1;
        check_val("lat_empty", 32'(empty), 32'd1);

        // Partial join must not be accepted
        in_req = 2'b10;
        repeat (10) @(posedge clk);
        #1;
        check_val("join_partial_ack", 32'(in_ack),    32'd1);
        check_val("join_partial_occ", 32'(occupancy), 32'd0);
        in_data = 16'h1234; in_req = 2'b00; sb.push_back(16'h1234);
        @(posedge clk); #1;
        check_val("join_complete_ack", 32'(in_ack), 32'd0);
        drain(20);

        // Stalled consumer fills the pipeline
        for (int v = 1; v <= 4; v++) offer(16'(v));
        repeat (6) @(posedge clk);
        #1;
        check_val("stall_full", 32'(full),      32'd1);
        check_val("stall_occ",  32'(occupancy), 32'd4);
        ack_before = in_ack;
        offer(16'h0005);
        repeat (5) @(posedge clk);
        #1;
        check_val("stall_fifth_unacked", 32'(in_ack), 32'(ack_before));
        check_val("stall_still_full",    32'(full),   32'd1);
        drain(60);
        check_val("stall_end_empty", 32'(empty), 32'd1);

        // Streaming with a mirroring consumer
        delivered = 0; sent = 0; cyc = 0;
        while (delivered < 20 && cyc < 100) begin
            if (sent < 20 && in_req == {N_IN{in_ack}}) begin
                in_data = 16'h1000 + 16'(sent);
                in_req  = ~in_req;
                sb.push_back(in_data);
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
            if (out_req != out_ack) begin
                if (sb.size() == 0) check_val("stream_spurious", 32'(sb.size()), 32'd1);
                else check_val("stream_data", 32'(out_data), 32'(sb.pop_front()));
                out_ack = ~out_ack;
                delivered++;
            end
        end
        #1;
        check_val("stream_delivered", 32'(delivered),  32'd20);
        check_val("stream_rate",      32'(cyc <= 44),  32'd1);
        check_val("stream_sb_empty",  32'(sb.size()),  32'd0);
        check_val("stream_empty",     32'(empty),      32'd1);

        // Reset with tokens in flight
        for (int v = 1; v <= 3; v++) offer(16'h2000 + 16'(v));
        repeat (6) @(posedge clk);
        #1;
        check_val("inflight_occ", 32'(occupancy), 32'd3);
        rst = 1'b1; in_req = 2'b11; out_ack = 1'b0; in_data = 16'hBEEF;
        @(posedge clk); #1;
        check_val("midrst_occ",     32'(occupancy), 32'd0);
        check_val("midrst_in_ack",  32'(in_ack),    32'd0);
        check_val("midrst_out_req", 32'(out_req),   32'd0);
        check_val("midrst_empty",   32'(empty),     32'd1);
        sb.delete();
        rst = 1'b0;
        sb.push_back(16'hBEEF);
        @(posedge clk); #1;
        check_val("postrst_in_ack", 32'(in_ack), 32'd1);
        drain(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muller_c_pipeline.md
# muller_c_pipeline

Parametrised, clocked Muller C-element micropipeline: an N-input join C-element feeds a chain of STAGES C-element/latch stages that carry data tokens under two-phase (transition) req/ack signalling. It generalises the project's single 2-input C-element to configurable join width, data width and depth. It adds data transport, back-pressure and occupancy status. It sits between the io-pad handshake inputs and the project's formal/cover harness.

## Interface
- STAGES, 4, number of C-element stages (≥2)
- WIDTH, 8, data bits per input channel
- N_IN, 2, number of joined input channels (≥1); stage data width DW = N_IN*WIDTH
- wb_clk_i  in  1  clock; all state updates on rising edge
- wb_rst_i  in  1  reset; synchronous and active-high
- in_req  in  N_IN  per-channel two-phase request
- in_data  in  DW  channel k at bits [k*WIDTH +: WIDTH]
- in_ack  out  1  two-phase acknowledge, shared by all channels
- out_req  out  1  two-phase request to consumer
- out_data  out  DW  data of head token
- out_ack  in  1  consumer acknowledge
- occupancy  out  $clog2(STAGES+1)  tokens held in stages
- empty  out  1  occupancy==0
- full  out  1  occupancy==STAGES

## Operation
- State: c[0..STAGES-1] (1 bit each), d[0..STAGES-1] (DW each).
- Boundary terms: c[STAGES] = out_ack; d[-1] = in_data.
- C-element rule, all stages updated simultaneously from current-cycle values:
  - stage 0 inputs: all in_req bits and ~c[1];
  - stage i>0 inputs: c[i-1] and ~c[i+1];
  - if all inputs are equal, c[i] takes that value; otherwise c[i] holds.
- d[i] <= d[i-1] exactly on cycles where c[i] changes; otherwise d[i] holds.
- Outputs:
  - in_ack = c[0];
  - out_req = c[STAGES-1];
  - out_data = d[STAGES-1];
  - occupancy = number of i in 0..STAGES-1 with c[i] != c[i+1].
- Token moves from stage i-1 into stage i only when stage i is empty in the current cycle. A stage vacated this cycle accepts its next token the following cycle.
- Join: a new input token is accepted only when every in_req bit differs from in_ack. Partial toggles wait without changing state.
- Protocol:
  - producer toggles in_req[k] only while in_req[k]==in_ack;
  - consumer toggles out_ack only while out_ack!=out_req.
  - Violations have no guaranteed behaviour; the bench flags them by assertion.

## Timing
- Reset: all c=0, d=0.
  - Outputs after reset: in_ack=0, out_req=0, out_data=0, occupancy=0, empty=1, full=0.
- Reset mid-operation discards all tokens on that edge.
  - Any in_req bit still 1 after reset counts as a pending transition.
- Input latency: in_ack toggles on the first rising edge at which all in_req bits are toggled and stage 1 is empty.
- Forward latency through an empty pipeline: out_req toggles STAGES-1 edges after in_ack; out_data is valid in the same cycle.
- Streaming throughput with an instantly mirroring consumer: one token per 2 cycles; FIFO order is preserved.
- Stalled consumer: pipeline fills to STAGES tokens, full=1, and in_ack stops toggling.
  - Each out_ack toggle frees the last stage; the freed slot propagates backward one stage per edge.
- Simultaneous in_req arrival and out_ack release: both are processed in the same edge under the per-stage rule; no priority logic.

## Structure
- Shared package muller_pkg:
  - C-element reset value constant (1'b0);
  - occupancy width function clog2p1(n).
- Sub-module muller_c_n:
  - parameter N;
  - inputs: wb_clk_i, wb_rst_i, N-bit in vector;
  - output: registered c;
  - generic synchronous C-element, instantiated STAGES times (stage 0 with N=N_IN+1, others N=2).
- Top: generate loop for stages and data registers, plus a combinational popcount for occupancy.

## Test plan
Defaults STAGES=4, WIDTH=8, N_IN=2.
- Reset held 3 cycles with in_req=2'b00 -> in_ack=0, out_req=0, out_data=16'h0000, occupancy=0, empty=1.
- in_data=16'hA55A, in_req 00->11 before edge 1 -> in_ack=1 after edge 1; out_req=1 and out_data=16'hA55A after edge 4; occupancy=1.
- Only in_req[0] toggled and held 10 cycles -> in_ack unchanged, occupancy unchanged. in_req[1] toggled -> in_ack toggles on the next edge.
- out_ack held; tokens 16'h0001..16'h0004 offered back-to-back:
  - full=1, occupancy=4, fifth token unacknowledged;
  - out_ack mirrored 4 times -> out_data 0001, 0002, 0003, 0004 in order, ending with empty=1.
- Consumer mirrors out_req each cycle; producer always ready for 40 cycles -> 20 tokens delivered, in order, no loss or duplication.
- Three tokens in flight, then reset pulse with in_req held at 2'b11 -> occupancy=0 after the reset edge. First edge after reset release: in_ack=1, new token with current in_data.
